// File: rtl/divider32.sv
// Sequential restoring radix-2 divider with valid/ready handshakes on both sides.
// Define DIVIDER32_SIGNED_EN to honour is_signed; otherwise all operands are unsigned.
module divider32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic             last_step;
   logic             zero_div;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH-1:0] dvd_raw;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;

`ifdef DIVIDER32_SIGNED_EN
   logic neg_q_q, neg_q_d;
   logic neg_r_q, neg_r_d;
   logic sgn_in;

   assign sgn_in  = is_signed;
   assign mag1    = (sgn_in && in1[WIDTH-1]) ? -in1 : in1;
   assign mag2    = (sgn_in && in2[WIDTH-1]) ? -in2 : in2;
   assign neg_q_d = accept ? (sgn_in & (in1[WIDTH-1] ^ in2[WIDTH-1])) : neg_q_q;
   assign neg_r_d = accept ? (sgn_in & in1[WIDTH-1]) : neg_r_q;
   assign q_fix   = neg_q_q ? -a_q : a_q;
   assign r_fix   = neg_r_q ? -r_q : r_q;
   // a_q still holds the untouched dividend magnitude when the divisor is zero
   assign dvd_raw = neg_r_q ? -a_q : a_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else begin
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
      end
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign mag1    = in1;
   assign mag2    = in2;
   assign q_fix   = a_q;
   assign r_fix   = r_q;
   assign dvd_raw = a_q;
`endif

   assign accept    = in_valid & in_ready;
   assign last_step = (cnt_q == CW'(WIDTH));
   assign zero_div  = (b_q == '0);
   assign r_shift   = {r_q, a_q[WIDTH-1]};
   assign diff      = r_shift - {1'b0, b_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = CALC;
         CALC: if (zero_div || last_step) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      r_d    = r_q;
      cnt_d  = cnt_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      if (state_q == IDLE && accept) begin
         a_d   = mag1;
         b_d   = mag2;
         r_d   = '0;
         cnt_d = '0;
      end else if (state_q == CALC) begin
         if (zero_div) begin
            quot_d = '1;
            rem_d  = dvd_raw;
            dbz_d  = 1'b1;
         end else if (last_step) begin
            quot_d = q_fix;
            rem_d  = r_fix;
            dbz_d  = 1'b0;
         end else begin
            // borrow clear means the trial subtraction fits: keep it and shift in a 1
            if (!diff[WIDTH]) begin
               r_d = diff[WIDTH-1:0];
               a_d = {a_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = r_shift[WIDTH-1:0];
               a_d = {a_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         r_q    <= r_d;
         cnt_q  <= cnt_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dbz_q  <= dbz_d;
      end
   end

   assign quot        = quot_q;
   assign rem         = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider32.sv
// Directed self-checking bench for divider32; signed expectations follow DIVIDER32_SIGNED_EN.
module tb_divider32;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        is_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   divider32 #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .is_signed(is_signed), .out_valid(out_valid),
      .out_ready(out_ready), .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Accept one operation, scramble the inputs, and count edges until out_valid.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
      @(negedge clk);
      in1 = a; in2 = b; is_signed = s; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in1 = $urandom; in2 = $urandom; is_signed = ~s;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0; is_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (quot !== 32'h0) begin errors++; $display("FAIL reset_quot: got %h want 0", quot); end
      checks++; if (rem !== 32'h0) begin errors++; $display("FAIL reset_rem: got %h want 0", rem); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_unsigned;
      int lat;
      do_op(32'd100, 32'd7, 1'b0, lat);
      checks++; if (lat !== 33) begin errors++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
      checks++; if (quot !== 32'd14) begin errors++; $display("FAIL u100_7_quot: got %h want %h", quot, 32'd14); end
      checks++; if (rem !== 32'd2) begin errors++; $display("FAIL u100_7_rem: got %h want %h", rem, 32'd2); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL u100_7_dbz: got %b want 0", div_by_zero); end
      take();
   endtask

   task automatic test_signed;
      int lat;
      logic [31:0] eq, er;
`ifdef DIVIDER32_SIGNED_EN
      eq = 32'hFFFFFFFD; er = 32'hFFFFFFFF;
`else
      eq = 32'h7FFFFFFC; er = 32'h00000001;
`endif
      do_op(32'hFFFFFFF9, 32'd2, 1'b1, lat);
      checks++; if (lat !== 33) begin errors++; $display("FAIL s_m7_2_latency: got %0d want 33", lat); end
      checks++; if (quot !== eq) begin errors++; $display("FAIL s_m7_2_quot: got %h want %h", quot, eq); end
      checks++; if (rem !== er) begin errors++; $display("FAIL s_m7_2_rem: got %h want %h", rem, er); end
      take();
      do_op(32'hFFFFFFF9, 32'd2, 1'b0, lat);
      checks++; if (quot !== 32'h7FFFFFFC) begin errors++; $display("FAIL u_m7_2_quot: got %h want 7ffffffc", quot); end
      checks++; if (rem !== 32'h1) begin errors++; $display("FAIL u_m7_2_rem: got %h want 1", rem); end
      take();
   endtask

   task automatic test_div_zero;
      int lat;
      do_op(32'd5, 32'd0, 1'b0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
      checks++; if (quot !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_quot: got %h want ffffffff", quot); end
      checks++; if (rem !== 32'd5) begin errors++; $display("FAIL dz_rem: got %h want 5", rem); end
      checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
      take();
      do_op(32'hFFFFFFF9, 32'd0, 1'b1, lat);
      checks++; if (rem !== 32'hFFFFFFF9) begin errors++; $display("FAIL dz_neg_rem: got %h want fffffff9", rem); end
      checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_neg_flag: got %b want 1", div_by_zero); end
      take();
   endtask

   task automatic test_overflow;
      int lat;
      logic [31:0] eq, er;
`ifdef DIVIDER32_SIGNED_EN
      eq = 32'h80000000; er = 32'h0;
`else
      eq = 32'h0; er = 32'h80000000;
`endif
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat);
      checks++; if (quot !== eq) begin errors++; $display("FAIL ovf_s_quot: got %h want %h", quot, eq); end
      checks++; if (rem !== er) begin errors++; $display("FAIL ovf_s_rem: got %h want %h", rem, er); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_s_dbz: got %b want 0", div_by_zero); end
      take();
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
      checks++; if (quot !== 32'h0) begin errors++; $display("FAIL ovf_u_quot: got %h want 0", quot); end
      checks++; if (rem !== 32'h80000000) begin errors++; $display("FAIL ovf_u_rem: got %h want 80000000", rem); end
      take();
   endtask

   task automatic test_back_to_back;
      int lat;
      do_op(32'd200, 32'd9, 1'b0, lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || quot !== 32'd22 || rem !== 32'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: got v=%b q=%h r=%h rdy=%b want v=1 q=16 r=2 rdy=0",
                     i, out_valid, quot, rem, in_ready);
         end
      end
      take();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL release_idle: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
      do_op(32'd1000, 32'd10, 1'b0, lat);
      checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
      checks++; if (quot !== 32'd100) begin errors++; $display("FAIL b2b_quot: got %h want %h", quot, 32'd100); end
      checks++; if (rem !== 32'd0) begin errors++; $display("FAIL b2b_rem: got %h want 0", rem); end
      take();
   endtask

   task automatic test_mid_reset;
      int lat;
      @(negedge clk);
      in1 = 32'd77; in2 = 32'd5; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      checks++; if (quot !== 32'h0 || rem !== 32'h0) begin errors++; $display("FAIL midrst_outputs: got q=%h r=%h want 0 0", quot, rem); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      do_op(32'd9, 32'd3, 1'b0, lat);
      checks++; if (lat !== 33) begin errors++; $display("FAIL midrst_latency: got %0d want 33", lat); end
      checks++; if (quot !== 32'd3 || rem !== 32'd0) begin errors++; $display("FAIL midrst_9_3: got q=%h r=%h want 3 0", quot, rem); end
      take();
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
